// File: rtl/encode_address_mode_pkg.sv
// Shared decode/encode definitions for the effective-address blocks (encoder
// and SIB decoder): ModR/M mod codes, rm/SIB escape values, scale codes,
// displacement size classes and the encoder FSM state type.
package encode_address_mode_pkg;

    localparam logic [1:0] MOD_NO_DISP = 2'b00;
    localparam logic [1:0] MOD_DISP8   = 2'b01;
    localparam logic [1:0] MOD_DISP32  = 2'b10;

    // rm = 100 selects a SIB byte; SIB index = 100 means "no index".
    localparam logic [2:0] RM_SIB_ESC  = 3'b100;
    // rm = 101 with mod = 00, or SIB base = 101 with mod = 00: disp32, no base.
    localparam logic [2:0] NO_BASE     = 3'b101;

    localparam logic [1:0] SCALE_X1    = 2'b00;
    localparam logic [1:0] SCALE_X2    = 2'b01;
    localparam logic [1:0] SCALE_X4    = 2'b10;
    localparam logic [1:0] SCALE_X8    = 2'b11;

    typedef enum logic [1:0] {
        DISP_NONE,
        DISP_8,
        DISP_32
    } disp_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODRM,
        ST_SIB,
        ST_DISP,
        ST_ERR
    } ea_state_t;

    // Byte n (0 = least significant) of a 32-bit displacement.
    function automatic logic [7:0] disp_byte(input logic [31:0] d, input logic [1:0] n);
        return d[8*n +: 8];
    endfunction

endpackage

// File: rtl/encode_address_mode_classify.sv
// encode_ea_classify: purely combinational classification of an effective
// address request into ModR/M byte, SIB need/byte, displacement size and
// an illegal flag (ESP cannot be an index).
//   reg_field, base_present/base_reg, index_present/index_reg, scale, disp : request
//   modrm, sib_needed, sib_byte, disp_size, illegal                        : results
module encode_ea_classify
    import encode_address_mode_pkg::*;
(
    input  logic [2:0]  reg_field,
    input  logic        base_present,
    input  logic [2:0]  base_reg,
    input  logic        index_present,
    input  logic [2:0]  index_reg,
    input  logic [1:0]  scale,
    input  logic [31:0] disp,
    output logic [7:0]  modrm,
    output logic        sib_needed,
    output logic [7:0]  sib_byte,
    output disp_size_t  disp_size,
    output logic        illegal
);

    logic       disp_is_zero;
    logic       disp_fits8;
    logic [1:0] mod_code;
    logic [2:0] rm_code;

    always_comb begin
        disp_is_zero = (disp == '0);
        // Sign-extension of bit 7 covers the whole word -> fits in [-128,127].
        disp_fits8   = (disp[31:7] == '0) || (disp[31:7] == '1);

        // Base absent with index present is already covered by index_present.
        sib_needed = index_present || (base_present && (base_reg == RM_SIB_ESC));
        illegal    = index_present && (index_reg == RM_SIB_ESC);

        // EBP as base has no mod=00 form, so a zero disp still needs disp8.
        if (!base_present)
            disp_size = DISP_32;
        else if (disp_is_zero && (base_reg != NO_BASE))
            disp_size = DISP_NONE;
        else if (disp_fits8)
            disp_size = DISP_8;
        else
            disp_size = DISP_32;

        case (disp_size)
            DISP_NONE: mod_code = MOD_NO_DISP;
            DISP_8:    mod_code = MOD_DISP8;
            default:   mod_code = base_present ? MOD_DISP32 : MOD_NO_DISP;
        endcase

        if (sib_needed)
            rm_code = RM_SIB_ESC;
        else if (!base_present)
            rm_code = NO_BASE;
        else
            rm_code = base_reg;

        modrm    = {mod_code, reg_field, rm_code};
        sib_byte = {index_present ? scale     : SCALE_X1,
                    index_present ? index_reg : RM_SIB_ESC,
                    base_present  ? base_reg  : NO_BASE};
    end

endmodule

// File: rtl/encode_address_mode.sv
// encode_address_mode: accepts an effective-address request and emits the
// x86 ModR/M, optional SIB and displacement bytes (LSB first) on a
// valid/ready byte stream. Unencodable requests produce a one-cycle o_err.
//   i_clk, i_rst                      : clock, synchronous active-high reset
//   i_req_valid / o_req_ready         : request handshake (ready only in IDLE)
//   i_reg_field, i_base_*, i_index_*,
//   i_scale, i_disp                   : request fields, captured on acceptance
//   o_byte_valid/o_byte/o_byte_last,
//   i_byte_ready                      : registered encoded byte stream
//   o_err                             : registered one-cycle error pulse
module encode_address_mode
    import encode_address_mode_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_reg_field,
    input  logic        i_base_present,
    input  logic [2:0]  i_base_reg,
    input  logic        i_index_present,
    input  logic [2:0]  i_index_reg,
    input  logic [1:0]  i_scale,
    input  logic [31:0] i_disp,
    output logic        o_byte_valid,
    output logic [7:0]  o_byte,
    output logic        o_byte_last,
    input  logic        i_byte_ready,
    output logic        o_err
);

    ea_state_t  state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic [7:0] byte_nx;
    logic       valid_nx, last_nx, err_nx;

    logic [7:0] c_modrm, c_sib;
    logic       c_sib_needed, c_illegal;
    disp_size_t c_disp_size;

    logic [7:0]  sib_q;
    logic        sib_needed_q;
    disp_size_t  disp_size_q;
    logic [31:0] disp_q;

    logic accept, handshake;
    logic [1:0] disp_last_idx;

    encode_ea_classify u_classify (
        .reg_field     (i_reg_field),
        .base_present  (i_base_present),
        .base_reg      (i_base_reg),
        .index_present (i_index_present),
        .index_reg     (i_index_reg),
        .scale         (i_scale),
        .disp          (i_disp),
        .modrm         (c_modrm),
        .sib_needed    (c_sib_needed),
        .sib_byte      (c_sib),
        .disp_size     (c_disp_size),
        .illegal       (c_illegal)
    );

    assign o_req_ready   = (state == ST_IDLE);
    assign accept        = i_req_valid && o_req_ready;
    assign handshake     = o_byte_valid && i_byte_ready;
    assign disp_last_idx = (disp_size_q == DISP_8) ? 2'd0 : 2'd3;

    // Classification runs on the live inputs at acceptance; the ModR/M byte
    // goes straight into o_byte and the rest is held for later states.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sib_q        <= '0;
            sib_needed_q <= 1'b0;
            disp_size_q  <= DISP_NONE;
            disp_q       <= '0;
        end else if (accept) begin
            sib_q        <= c_sib;
            sib_needed_q <= c_sib_needed;
            disp_size_q  <= c_disp_size;
            disp_q       <= i_disp;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_byte_last  <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            o_byte       <= byte_nx;
            o_byte_valid <= valid_nx;
            o_byte_last  <= last_nx;
            o_err        <= err_nx;
        end
    end

    // Next state and next registered outputs: each transition loads the
    // byte that the destination state presents.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        byte_nx  = o_byte;
        valid_nx = o_byte_valid;
        last_nx  = o_byte_last;
        err_nx   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (c_illegal) begin
                        state_nx = ST_ERR;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = ST_MODRM;
                        byte_nx  = c_modrm;
                        valid_nx = 1'b1;
                        last_nx  = !c_sib_needed && (c_disp_size == DISP_NONE);
                    end
                end
            end
            ST_MODRM, ST_SIB: begin
                if (handshake) begin
                    if ((state == ST_MODRM) && sib_needed_q) begin
                        state_nx = ST_SIB;
                        byte_nx  = sib_q;
                        last_nx  = (disp_size_q == DISP_NONE);
                    end else if (disp_size_q != DISP_NONE) begin
                        state_nx = ST_DISP;
                        cnt_nx   = '0;
                        byte_nx  = disp_q[7:0];
                        last_nx  = (disp_size_q == DISP_8);
                    end else begin
                        state_nx = ST_IDLE;
                        valid_nx = 1'b0;
                        last_nx  = 1'b0;
                    end
                end
            end
            ST_DISP: begin
                if (handshake) begin
                    if (cnt == disp_last_idx) begin
                        state_nx = ST_IDLE;
                        valid_nx = 1'b0;
                        last_nx  = 1'b0;
                    end else begin
                        cnt_nx  = cnt + 2'd1;
                        byte_nx = disp_byte(disp_q, cnt + 2'd1);
                        last_nx = ((cnt + 2'd1) == 2'd3);
                    end
                end
            end
            ST_ERR: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                valid_nx = 1'b0;
                last_nx  = 1'b0;
            end
        endcase
    end

endmodule
